// File: rtl/u_sequencer.sv
// ============================================================================
// Module   : u_sequencer
// Purpose  : Microcode sequencer; next micro-address and fetch-boundary events.
//            Optional macro U_SEQ_TRACE_EN adds trace_addr / trace_cnt.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module u_sequencer #(
  parameter int OPC_W      = 8,
  parameter int STEP_W     = 6,
  parameter int FETCH_ADDR = 0,
  parameter int IRQ_ADDR   = 64
) (
  input  logic                      clk,
  input  logic                      arst,
  input  logic [1:0]                typ,
  input  logic [6:0]                u_offset,
  input  logic                      cond_invert,
  input  logic                      cond_flag_src,
  input  logic [3:0]                cond_sel,
  input  logic                      escape,
  input  logic [3:0]                flags,
  input  logic [3:0]                u_flags,
  input  logic [OPC_W-1:0]          ir,
  input  logic                      irq_pending,
  input  logic                      irq_en,
  input  logic                      dma_req,
  input  logic                      halt_req,
  input  logic                      mem_wait,
  output logic [OPC_W+STEP_W:0]     u_addr,
`ifdef U_SEQ_TRACE_EN
  output logic [OPC_W+STEP_W:0]     trace_addr,
  output logic [15:0]               trace_cnt,
`endif
  output logic                      dma_ack,
  output logic                      halted,
  output logic                      irq_taken,
  output logic                      cond_true
);

  localparam int AW = 1 + OPC_W + STEP_W;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_DMA  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t              r_state;
  logic [AW-1:0]       r_u_addr;
  logic                r_esc_latch;
  logic                r_dma_ack;
  logic                r_halted;
  logic                r_irq_taken;

  logic [3:0]          w_f;
  logic                w_c;
  logic [STEP_W-1:0]   w_step;
  logic [STEP_W-1:0]   w_step_inc;
  logic [STEP_W-1:0]   w_step_br;
  logic [AW-1:0]       w_fetch_addr;
  logic [AW-1:0]       w_irq_addr;

  // F bit order is {OF,SF,CF,ZF}
  always_comb begin
    w_f = cond_flag_src ? u_flags : flags;
    w_c = 1'b0;
    case (cond_sel)
      4'd0:    w_c = w_f[0];
      4'd1:    w_c = w_f[1];
      4'd2:    w_c = w_f[2];
      4'd3:    w_c = w_f[3];
      4'd4:    w_c = w_f[2] ^ w_f[3];
      4'd5:    w_c = w_f[0] | (w_f[2] ^ w_f[3]);
      4'd6:    w_c = w_f[1] | w_f[0];
      4'd7:    w_c = dma_req;
      4'd8:    w_c = irq_pending;
      default: w_c = 1'b0;
    endcase
  end

  assign cond_true    = cond_invert ^ w_c;
  assign w_step       = r_u_addr[STEP_W-1:0];
  assign w_step_inc   = w_step + STEP_W'(1);
  assign w_step_br    = w_step + STEP_W'({{STEP_W{u_offset[6]}}, u_offset});
  assign w_fetch_addr = AW'(FETCH_ADDR);
  assign w_irq_addr   = AW'(IRQ_ADDR);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state     <= S_RUN;
      r_u_addr    <= AW'(FETCH_ADDR);
      r_esc_latch <= 1'b0;
      r_dma_ack   <= 1'b0;
      r_halted    <= 1'b0;
      r_irq_taken <= 1'b0;
    end else begin
      r_irq_taken <= 1'b0;
      if (!mem_wait) begin
        case (r_state)
          S_RUN: begin
            // DECODE consumes the old latch, then takes this word's ESCAPE
            if (typ == 2'd3)
              r_esc_latch <= escape;
            else if (escape)
              r_esc_latch <= 1'b1;
            case (typ)
              2'd0: r_u_addr[STEP_W-1:0] <= w_step_inc;
              2'd1: r_u_addr[STEP_W-1:0] <= cond_true ? w_step_br : w_step_inc;
              2'd2: begin
                if (dma_req) begin
                  r_state   <= S_DMA;
                  r_dma_ack <= 1'b1;
                end else if (irq_pending && irq_en && !r_esc_latch) begin
                  r_u_addr    <= w_irq_addr;
                  r_irq_taken <= 1'b1;
                end else if (halt_req) begin
                  r_state  <= S_HALT;
                  r_halted <= 1'b1;
                end else begin
                  r_u_addr <= w_fetch_addr;
                end
              end
              default: r_u_addr <= {r_esc_latch, ir, {STEP_W{1'b0}}};
            endcase
          end
          S_DMA: begin
            if (!dma_req) begin
              r_state   <= S_RUN;
              r_dma_ack <= 1'b0;
              r_u_addr  <= w_fetch_addr;
            end
          end
          S_HALT: begin
            if (dma_req) begin
              r_state   <= S_DMA;
              r_halted  <= 1'b0;
              r_dma_ack <= 1'b1;
            end else if (irq_pending && irq_en) begin
              r_state     <= S_RUN;
              r_halted    <= 1'b0;
              r_u_addr    <= w_irq_addr;
              r_irq_taken <= 1'b1;
            end else if (!halt_req) begin
              r_state  <= S_RUN;
              r_halted <= 1'b0;
              r_u_addr <= w_fetch_addr;
            end
          end
          default: r_state <= S_RUN;
        endcase
      end
    end
  end

  assign u_addr    = r_u_addr;
  assign dma_ack   = r_dma_ack;
  assign halted    = r_halted;
  assign irq_taken = r_irq_taken;

`ifdef U_SEQ_TRACE_EN
  logic          w_br_taken;
  logic          w_irq_entry;
  logic [AW-1:0] r_trace_addr;
  logic [15:0]   r_trace_cnt;

  assign w_br_taken  = (r_state == S_RUN) && !mem_wait && (typ == 2'd1) && cond_true;
  assign w_irq_entry = !mem_wait && !dma_req && irq_pending && irq_en &&
                       (((r_state == S_RUN) && (typ == 2'd2) && !r_esc_latch) ||
                        (r_state == S_HALT));

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_trace_addr <= '0;
      r_trace_cnt  <= '0;
    end else begin
      if (w_br_taken || w_irq_entry)
        r_trace_addr <= r_u_addr;
      if (w_br_taken && (r_trace_cnt != 16'hFFFF))
        r_trace_cnt <= r_trace_cnt + 16'd1;
    end
  end

  assign trace_addr = r_trace_addr;
  assign trace_cnt  = r_trace_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_u_sequencer.sv
// ============================================================================
// Module   : tb_u_sequencer
// Purpose  : Directed self-checking bench for u_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_u_sequencer;

  logic        clk = 1'b0;
  logic        arst;
  logic [1:0]  typ;
  logic [6:0]  u_offset;
  logic        cond_invert, cond_flag_src;
  logic [3:0]  cond_sel;
  logic        escape;
  logic [3:0]  flags, u_flags;
  logic [7:0]  ir;
  logic        irq_pending, irq_en, dma_req, halt_req, mem_wait;
  logic [14:0] u_addr;
  logic        dma_ack, halted, irq_taken, cond_true;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  u_sequencer dut (
    .clk(clk), .arst(arst), .typ(typ), .u_offset(u_offset),
    .cond_invert(cond_invert), .cond_flag_src(cond_flag_src), .cond_sel(cond_sel),
    .escape(escape), .flags(flags), .u_flags(u_flags), .ir(ir),
    .irq_pending(irq_pending), .irq_en(irq_en), .dma_req(dma_req),
    .halt_req(halt_req), .mem_wait(mem_wait), .u_addr(u_addr),
    .dma_ack(dma_ack), .halted(halted), .irq_taken(irq_taken), .cond_true(cond_true)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    arst = 1'b1; typ = 2'd0; u_offset = '0; cond_invert = 0; cond_flag_src = 0;
    cond_sel = '0; escape = 0; flags = '0; u_flags = '0; ir = '0;
    irq_pending = 0; irq_en = 0; dma_req = 0; halt_req = 0; mem_wait = 0;
    tick(); tick();
    arst = 1'b0;

    // walk to a mid-page address, then reset asynchronously
    for (int i = 0; i < 5; i++) tick();
    check("pre_reset_addr", u_addr, 15'h0005);
    arst = 1'b1;
    #1;
    check("reset_addr", u_addr, 15'h0000);
    check("reset_dma_ack", dma_ack, 1'b0);
    check("reset_halted", halted, 1'b0);
    check("reset_irq_taken", irq_taken, 1'b0);
    tick();
    arst = 1'b0;
    tick();
    check("post_release_next", u_addr, 15'h0001);

    // DECODE without and with ESCAPE
    ir = 8'h3A; typ = 2'd3;
    tick();
    check("decode_plain", u_addr, 15'h0E80);
    typ = 2'd0; escape = 1;
    tick();
    check("escape_word_next", u_addr, 15'h0E81);
    typ = 2'd3; escape = 0;
    tick();
    check("decode_escaped", u_addr, 15'h4E80);
    tick();
    check("decode_latch_cleared", u_addr, 15'h0E80);

    // walk to step 10, then branch back -4 on ZF
    typ = 2'd0;
    for (int i = 0; i < 10; i++) tick();
    check("step10", u_addr, 15'h0E8A);
    typ = 2'd1; u_offset = 7'h7C; cond_sel = 4'd0; flags = 4'b0001;
    #1;
    check("cond_zf", cond_true, 1'b1);
    tick();
    check("branch_taken_back", u_addr, 15'h0E86);
    typ = 2'd0;
    for (int i = 0; i < 4; i++) tick();
    typ = 2'd1; cond_invert = 1;
    tick();
    check("branch_inverted_fallthru", u_addr, 15'h0E8B);

    // branch forward to step 63, then NEXT wraps within the page
    cond_invert = 0; u_offset = 7'h34;
    tick();
    check("branch_to_63", u_addr, 15'h0EBF);
    typ = 2'd0;
    tick();
    check("step_wrap", u_addr, 15'h0E80);

    // combinational condition decode
    flags = 4'b0100; cond_sel = 4'd4;
    #1 check("cond_sf_xor_of", cond_true, 1'b1);
    cond_flag_src = 1; u_flags = 4'b1100;
    #1 check("cond_uflags_sf_xor_of", cond_true, 1'b0);
    cond_sel = 4'd5; u_flags = 4'b0001;
    #1 check("cond_le", cond_true, 1'b1);
    cond_sel = 4'd6; u_flags = 4'b0010;
    #1 check("cond_cf_or_zf", cond_true, 1'b1);
    cond_sel = 4'd7; dma_req = 1;
    #1 check("cond_dma_req", cond_true, 1'b1);
    dma_req = 0; cond_sel = 4'd9; cond_invert = 1;
    #1 check("cond_sel9_inverted", cond_true, 1'b1);
    cond_invert = 0; cond_flag_src = 0; cond_sel = 4'd0; flags = 4'b0001;

    // stall a taken BRANCH for three cycles
    typ = 2'd1; u_offset = 7'h05; mem_wait = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold", u_addr, 15'h0E80);
    end
    mem_wait = 0;
    tick();
    check("stall_release_branch", u_addr, 15'h0E85);
    typ = 2'd0;
    tick();
    check("after_branch_next", u_addr, 15'h0E86);

    // FETCH with DMA, IRQ pending: DMA wins
    typ = 2'd2; dma_req = 1; irq_pending = 1; irq_en = 1;
    tick();
    check("dma_enter_ack", dma_ack, 1'b1);
    check("dma_enter_addr_held", u_addr, 15'h0E86);
    check("dma_no_irq", irq_taken, 1'b0);
    tick();
    check("dma_hold_addr", u_addr, 15'h0E86);
    dma_req = 0;
    tick();
    check("dma_exit_addr", u_addr, 15'h0000);
    check("dma_exit_ack", dma_ack, 1'b0);
    tick();
    check("irq_entry_addr", u_addr, 15'h0040);
    check("irq_taken_pulse", irq_taken, 1'b1);
    typ = 2'd0; irq_pending = 0;
    tick();
    check("irq_taken_cleared", irq_taken, 1'b0);
    check("irq_routine_next", u_addr, 15'h0041);

    // pending ESCAPE blocks interrupt entry at FETCH
    escape = 1;
    tick();
    escape = 0; typ = 2'd2; irq_pending = 1;
    tick();
    check("esc_blocks_irq_addr", u_addr, 15'h0000);
    check("esc_blocks_irq_pulse", irq_taken, 1'b0);
    typ = 2'd3; irq_pending = 0;
    tick();
    check("esc_decode", u_addr, 15'h4E80);

    // HALT and exit via interrupt
    typ = 2'd2; halt_req = 1;
    tick();
    check("halt_enter", halted, 1'b1);
    check("halt_addr_held", u_addr, 15'h4E80);
    tick();
    check("halt_stays", halted, 1'b1);
    irq_pending = 1;
    tick();
    check("halt_irq_addr", u_addr, 15'h0040);
    check("halt_irq_halted", halted, 1'b0);
    check("halt_irq_pulse", irq_taken, 1'b1);
    irq_pending = 0; halt_req = 0; typ = 2'd0;
    tick();
    check("halt_irq_pulse_end", irq_taken, 1'b0);
    check("halt_irq_next", u_addr, 15'h0041);

    // HALT and exit by dropping halt_req
    typ = 2'd2; halt_req = 1;
    tick();
    check("halt2_enter", halted, 1'b1);
    halt_req = 0;
    tick();
    check("halt2_exit_addr", u_addr, 15'h0000);
    check("halt2_exit_halted", halted, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
